// File: rtl/reg_file_rd.sv
// reg_file_rd: 2^A x W register file with one write port and a handshaked
// dual-operand read port. A request is captured on its accepting edge. Both
// operands become visible one cycle later in a single registered output
// stage. Entry 0 always reads as zero.
module reg_file_rd #(
    parameter int W = 32,
    parameter int A = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         rd_req_valid,
    output logic         rd_req_ready,
    input  logic [A-1:0] rd_addr_a,
    input  logic [A-1:0] rd_addr_b,
    output logic         rd_rsp_valid,
    input  logic         rd_rsp_ready,
    output logic [W-1:0] rd_data_a,
    output logic [W-1:0] rd_data_b
);

    localparam int DEPTH = 32'd1 << A;

    logic [W-1:0] mem_r [DEPTH];
    logic         rsp_valid_r;
    logic [W-1:0] data_a_r;
    logic [W-1:0] data_b_r;

    logic         accept_s;
    logic         complete_s;
    logic         wr_hit_s;
    logic [W-1:0] oper_a_s;
    logic [W-1:0] oper_b_s;

    // The single output stage may be refilled whenever it is empty or being drained
    assign rd_req_ready = !rsp_valid_r || rd_rsp_ready;
    assign accept_s     = rd_req_valid && rd_req_ready;
    assign complete_s   = rsp_valid_r && rd_rsp_ready;
    // Writes to entry 0 are discarded, so they never count as a bypass source
    assign wr_hit_s     = wr_en && (wr_addr != {A{1'b0}});

    assign rd_rsp_valid = rsp_valid_r;
    assign rd_data_a    = data_a_r;
    assign rd_data_b    = data_b_r;

    // Operand A lookup: zero for entry 0, same-edge write data wins over stored entry
    always_comb begin
        oper_a_s = {W{1'b0}};
        if (rd_addr_a == {A{1'b0}}) begin
            oper_a_s = {W{1'b0}};
        end else if (wr_hit_s && (wr_addr == rd_addr_a)) begin
            oper_a_s = wr_data;
        end else begin
            oper_a_s = mem_r[rd_addr_a];
        end
    end

    // Operand B lookup: same rules as operand A, evaluated independently
    always_comb begin
        oper_b_s = {W{1'b0}};
        if (rd_addr_b == {A{1'b0}}) begin
            oper_b_s = {W{1'b0}};
        end else if (wr_hit_s && (wr_addr == rd_addr_b)) begin
            oper_b_s = wr_data;
        end else begin
            oper_b_s = mem_r[rd_addr_b];
        end
    end

    // Storage array: cleared by reset, written on any non-zero address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (wr_hit_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Response stage: load on accept, release on drain, otherwise hold the snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            data_a_r    <= {W{1'b0}};
            data_b_r    <= {W{1'b0}};
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            data_a_r    <= oper_a_s;
            data_b_r    <= oper_b_s;
        end else if (complete_s) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

endmodule

// File: tb/tb_reg_file_rd.sv
// Directed bench for reg_file_rd. A reference model of the register file
// predicts each response when the request is accepted. The prediction is
// queued and checked against the DUT output when that response is consumed.
module tb_reg_file_rd;

    localparam int W = 32;
    localparam int A = 5;
    localparam int DEPTH = 32;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         rd_req_valid;
    logic         rd_req_ready;
    logic [A-1:0] rd_addr_a;
    logic [A-1:0] rd_addr_b;
    logic         rd_rsp_valid;
    logic         rd_rsp_ready;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;

    reg_file_rd #(.W(W), .A(A)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  model_mem [DEPTH];
    logic          model_valid;
    logic [W-1:0]  last_a;
    logic [W-1:0]  last_b;
    logic [2*W-1:0] sb_q [$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_read(input logic [A-1:0] addr);
        logic [W-1:0] v;
        if (addr == 5'd0) v = 32'd0;
        else if (wr_en && wr_addr != 5'd0 && wr_addr == addr) v = wr_data;
        else v = model_mem[addr];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        model_valid = 1'b0;
        last_a = 32'd0;
        last_b = 32'd0;
        sb_q.delete();
    endtask

    // Check the outputs visible in this cycle, update the model, then advance one edge
    task automatic tick(input string tag);
        logic [2*W-1:0] e;
        logic acc;
        #1;
        chk({tag, ":rsp_valid"}, {31'd0, rd_rsp_valid}, {31'd0, model_valid});
        chk({tag, ":req_ready"}, {31'd0, rd_req_ready}, {31'd0, (!model_valid || rd_rsp_ready)});
        if (model_valid) begin
            if (sb_q.size() == 0) begin
                chk({tag, ":sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q[0];
                chk({tag, ":data_a"}, rd_data_a, e[2*W-1:W]);
                chk({tag, ":data_b"}, rd_data_b, e[W-1:0]);
                if (rd_rsp_ready) begin
                    void'(sb_q.pop_front());
                    last_a = e[2*W-1:W];
                    last_b = e[W-1:0];
                end
            end
        end else begin
            chk({tag, ":hold_a"}, rd_data_a, last_a);
            chk({tag, ":hold_b"}, rd_data_b, last_b);
        end
        acc = rd_req_valid && (!model_valid || rd_rsp_ready);
        if (acc) begin
            sb_q.push_back({model_read(rd_addr_a), model_read(rd_addr_b)});
            model_valid = 1'b1;
        end else if (model_valid && rd_rsp_ready) begin
            model_valid = 1'b0;
        end
        if (wr_en && wr_addr != 5'd0) model_mem[wr_addr] = wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input string tag,
                         input logic we, input logic [A-1:0] wa, input logic [W-1:0] wd,
                         input logic rv, input logic [A-1:0] ra, input logic [A-1:0] rb,
                         input logic rr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req_valid = rv; rd_addr_a = ra; rd_addr_b = rb;
        rd_rsp_ready = rr;
        tick(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        rd_req_valid = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        rd_rsp_ready = 1'b0;
        model_reset();

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst:valid", {31'd0, rd_rsp_valid}, 32'd0);
        chk("rst:data_a", rd_data_a, 32'd0);
        chk("rst:data_b", rd_data_b, 32'd0);
        rst_n = 1'b1;

        // Read after reset returns zeros
        drive("rd0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd7, 1'b1);
        drive("rd0r", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Write then read, plus address-0 write ignored
        drive("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b1);
        drive("rd5", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b1);
        drive("wr0", 1'b1, 5'd0, 32'h00001234, 1'b1, 5'd0, 5'd5, 1'b1);
        drive("wr0b", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b1);
        drive("idle1", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Bypass on both operands
        drive("wr9", 1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 5'd0, 1'b1);
        drive("byp", 1'b1, 5'd9, 32'h22222222, 1'b1, 5'd9, 5'd9, 1'b1);
        drive("bypa", 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd9, 5'd3, 1'b1);
        drive("idle2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Stall snapshot: held response ignores later writes
        drive("wr4", 1'b1, 5'd4, 32'h0000000A, 1'b0, 5'd0, 5'd0, 1'b1);
        drive("acc4", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 1'b0);
        drive("stl1", 1'b1, 5'd4, 32'h0000000B, 1'b1, 5'd4, 5'd4, 1'b0);
        drive("stl2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 1'b0);
        drive("stl3", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        drive("drn", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        drive("rd4", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 1'b1);
        drive("idle3", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        drive("idle4", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Throughput: fill 1..8 then read back-to-back
        for (int i = 1; i <= 8; i++) begin
            drive("fill", 1'b1, A'(i), 32'(i * 32'h100), 1'b0, 5'd0, 5'd0, 1'b1);
        end
        for (int i = 1; i <= 8; i++) begin
            drive("thru", 1'b0, 5'd0, 32'd0, 1'b1, A'(i), A'(9 - i), 1'b1);
        end
        drive("thru_end", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        drive("thru_idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);

        // Reset between edges while a response is held
        drive("pre_rst", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd5, 1'b0);
        chk("pre_rst:valid", {31'd0, rd_rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst:valid", {31'd0, rd_rsp_valid}, 32'd0);
        chk("arst:data_a", rd_data_a, 32'd0);
        chk("arst:data_b", rd_data_b, 32'd0);
        model_reset();
        rd_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            drive("post_rst", 1'b0, 5'd0, 32'd0, 1'b1, A'(i), A'(DEPTH - 1 - i), 1'b1);
        end
        drive("post_end", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        drive("post_idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_rd.md
Name: reg_file_rd

Overview:
- Register file with 2^A entries of W bits.
- One write port and one handshaked dual-operand read port with registered outputs.
- Sits between the decode stage and the ALU operand registers. The read side takes a request, then delivers both operands one cycle later under valid/ready back-pressure.
- Entry 0 is hardwired to zero.

Parameters:
- W, 32, data width of each entry.
- A, 5, address width; depth = 2^A entries.

Ports:
- clk  input  1  clock, all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write enable.
- wr_addr  input  A  write address.
- wr_data  input  W  write data.
- rd_req_valid  input  1  read request valid.
- rd_req_ready  output  1  read request can be accepted this cycle.
- rd_addr_a  input  A  operand A address.
- rd_addr_b  input  A  operand B address.
- rd_rsp_valid  output  1  rd_data_a/b hold a valid response.
- rd_rsp_ready  input  1  consumer accepts response.
- rd_data_a  output  W  operand A data (registered).
- rd_data_b  output  W  operand B data (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries become 0.
  - rd_rsp_valid = 0, rd_data_a = 0, rd_data_b = 0.
  - Reset takes effect immediately, mid-transaction included; any in-flight response is dropped.
  - Outputs leave reset on the first posedge after rst_n rises.
- Write:
  - On posedge with wr_en=1 and wr_addr!=0: entry[wr_addr] <= wr_data.
  - A write to address 0 is ignored; entry 0 always reads 0.
  - A write is never back-pressured.
- Request acceptance:
  - rd_req_ready = !rd_rsp_valid || rd_rsp_ready (combinational, single output stage).
  - A request is accepted on a posedge where rd_req_valid && rd_req_ready.
- Response:
  - On acceptance, rd_data_a/b are loaded and rd_rsp_valid <= 1.
  - Latency: exactly 1 cycle from acceptance edge to data visible.
  - Back-to-back accepts every cycle are allowed when rd_rsp_ready=1; this gives full throughput.
- Completion without a new request:
  - Condition: rd_rsp_valid && rd_rsp_ready at a posedge, with no new accept.
  - rd_rsp_valid <= 0.
  - rd_data_a/b keep their last value; they are don't-care but must not change.
- Stall:
  - While rd_rsp_valid && !rd_rsp_ready, rd_data_a/b and rd_rsp_valid are held stable.
  - A later write to the same address does NOT update the held response (snapshot semantics).
- Write bypass:
  - Condition: an accepting edge coincides with wr_en=1 to address X!=0, and rd_addr_a==X (or rd_addr_b==X).
  - That operand returns wr_data, not the old entry.
  - The bypass applies independently to each operand; both operands may bypass at once.
- Address-0 read: returns 0 even if the same-cycle write targets 0.
- Same address on both operands: both outputs are equal, bypass included.
- rd_req_valid may drop without being accepted; nothing is stored.

Test Plan:
- Reset, then read: assert rst_n=0 for 2 cycles, then request a=3, b=7 → rd_rsp_valid=1 one cycle after accept, rd_data_a=0, rd_data_b=0.
- Write then read:
  - Stimulus: write entry5=0xDEADBEEF, then next cycle request a=5, b=0.
  - Required: rd_data_a=0xDEADBEEF, rd_data_b=0; writing 0x1234 to addr 0 and reading a=0 still yields 0.
- Bypass:
  - Stimulus: entry9=0x11111111; in the same cycle wr_en with addr9=0x22222222 and accept request a=9, b=9.
  - Required: both outputs are 0x22222222.
- Stall snapshot:
  - Stimulus: accept a=4 (entry4=0xA); hold rd_rsp_ready=0 for 3 cycles while writing entry4=0xB.
  - Required: rd_data_a stays 0xA with rd_rsp_valid=1 and rd_req_ready=0; after ready, a fresh read of 4 returns 0xB.
- Throughput: with rd_rsp_ready=1, issue requests every cycle for addresses 1..8 (entry i = i*0x100) → 8 consecutive valid responses 0x100..0x800 with no bubbles.
- Reset mid-operation: drop rst_n asynchronously between edges while rd_rsp_valid=1 → rd_rsp_valid and data go to 0 immediately, and all entries read 0 afterward.
